systolic_array_ws: RTL and testbench

Parametrised weight-stationary systolic matrix-vector engine: the next-generation array tile for the TPU datapath. It adds configurable data and accumulator widths, double-buffered weights loaded from the top edge, internal input skew and output deskew, and a valid/ready handshake. Each accepted activation vector `a` (ROWS elements) produces one aligned result vector `y[c] = Σ_r a[r]·W[r][c]` (COLS elements). It sits between the activation buffer (left side) and the accumulator/activation unit (bottom side).

---
 rtl/systolic_array_ws.sv | 172 +++++++++++++++++
 tb/tb_systolic_array_ws.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ws.sv
// Weight-stationary systolic matrix-vector engine: y[c] = sum_r a[r]*W[r][c].
// Double-buffered weights, internal input skew / output deskew, valid/ready input handshake.
module systolic_array_ws #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 20,
   parameter bit          SIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_load,
   input  logic [DATA_W-1:0] w_in [0:COLS-1],
   input  logic              w_swap,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [DATA_W-1:0] a_in [0:ROWS-1],
   output logic              y_valid,
   output logic [ACC_W-1:0]  y_out [0:COLS-1],
   output logic              busy
);
   localparam int unsigned VLEN  = ROWS + COLS;
   localparam int unsigned CNT_W = $clog2(ROWS + COLS + 1);

   if (ACC_W < 2 * DATA_W + $clog2(ROWS)) begin : g_acc_w_check
      $error("systolic_array_ws: ACC_W too narrow for DATA_W and ROWS");
   end

   typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [VLEN-1:0]    vsr;
   logic               accept;

   logic [DATA_W-1:0]  sh_w   [ROWS][COLS];
   logic [DATA_W-1:0]  act_w  [ROWS][COLS];
   logic [DATA_W-1:0]  a_gate [ROWS];
   logic [DATA_W-1:0]  skew   [ROWS][ROWS];
   logic [DATA_W-1:0]  a_x    [ROWS][COLS];
   logic [DATA_W-1:0]  a_reg  [ROWS][COLS];
   logic [ACC_W-1:0]   p_x    [ROWS][COLS];
   logic [ACC_W-1:0]   psum   [ROWS][COLS];
   logic [ACC_W-1:0]   dsk    [COLS][COLS];
   logic [ACC_W-1:0]   aligned[COLS];

   function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] x);
      return SIGNED ? {{(ACC_W-DATA_W){x[DATA_W-1]}}, x} : {{(ACC_W-DATA_W){1'b0}}, x};
   endfunction

   assign a_ready = (state == RUN) && !reset;
   assign accept  = a_valid && a_ready;
   assign y_valid = vsr[VLEN-1];
   assign busy    = (cnt != '0) || (state != RUN);

   always_comb begin
      cnt_nxt = cnt;
      if (accept && !y_valid)
         cnt_nxt = cnt + CNT_W'(1);
      else if (!accept && y_valid)
         cnt_nxt = cnt - CNT_W'(1);
   end

   // DRAIN leaves in the cycle showing the last result, so SWAP directly follows it
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (w_swap) state_nxt = (cnt == '0 && !accept) ? SWAP : DRAIN;
         DRAIN:   if (cnt_nxt == '0) state_nxt = SWAP;
         SWAP:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
         vsr   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         vsr   <= {vsr[VLEN-2:0], accept};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++) begin
               sh_w[r][c]  <= '0;
               act_w[r][c] <= '0;
            end
      end else begin
         if (state == SWAP)
            act_w <= sh_w;
         if (w_load) begin
            for (int unsigned c = 0; c < COLS; c++)
               sh_w[0][c] <= w_in[c];
            for (int unsigned r = 1; r < ROWS; r++)
               sh_w[r] <= sh_w[r-1];
         end
      end
   end

   // Row r taps the r-th stage of a whole-vector delay line; zeros fill bubbles.
   always_comb begin
      for (int unsigned r = 0; r < ROWS; r++)
         a_gate[r] = accept ? a_in[r] : '0;
   end

   always_comb begin
      a_x[0][0] = a_gate[0];
      for (int unsigned r = 1; r < ROWS; r++)
         a_x[r][0] = skew[r-1][r];
      for (int unsigned r = 0; r < ROWS; r++)
         for (int unsigned c = 1; c < COLS; c++)
            a_x[r][c] = a_reg[r][c-1];
      for (int unsigned c = 0; c < COLS; c++) begin
         p_x[0][c] = '0;
         for (int unsigned r = 1; r < ROWS; r++)
            p_x[r][c] = psum[r-1][c];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned s = 0; s < ROWS; s++)
               skew[s][r] <= '0;
            for (int unsigned c = 0; c < COLS; c++) begin
               a_reg[r][c] <= '0;
               psum[r][c]  <= '0;
            end
         end
      end else begin
         skew[0] <= a_gate;
         for (int unsigned s = 1; s < ROWS; s++)
            skew[s] <= skew[s-1];
         for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++) begin
               a_reg[r][c] <= a_x[r][c];
               psum[r][c]  <= p_x[r][c] + ext(a_x[r][c]) * ext(act_w[r][c]);
            end
      end
   end

   // Column c leaves the array c cycles late; it waits COLS-1-c more here.
   always_comb begin
      for (int unsigned c = 0; c + 1 < COLS; c++)
         aligned[c] = dsk[COLS-2-c][c];
      aligned[COLS-1] = psum[ROWS-1][COLS-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            y_out[c] <= '0;
            for (int unsigned s = 0; s < COLS; s++)
               dsk[s][c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < COLS; c++)
            dsk[0][c] <= psum[ROWS-1][c];
         for (int unsigned s = 1; s < COLS; s++)
            dsk[s] <= dsk[s-1];
         if (vsr[VLEN-2])
            for (int unsigned c = 0; c < COLS; c++)
               y_out[c] <= aligned[c];
      end
   end
endmodule

// File: tb/tb_systolic_array_ws.sv
// Bench for systolic_array_ws: directed scenarios plus random traffic, scored
// against a matrix-vector model with a queue of outstanding results.
module tb_systolic_array_ws;
   localparam int ROWS = 4, COLS = 4, DW = 8, AW = 20;
   localparam int LAT = ROWS + COLS;

   typedef logic [ROWS*DW-1:0]      avec_t;
   typedef logic [COLS*AW-1:0]      yvec_t;
   typedef logic [ROWS*COLS*DW-1:0] wmat_t;

   logic clk = 1'b0, reset = 1'b1, w_load = 1'b0, w_swap = 1'b0, a_valid = 1'b0;
   logic [DW-1:0] w_in [0:COLS-1];
   logic [DW-1:0] a_in [0:ROWS-1];
   logic a_ready, y_valid, busy;
   logic [AW-1:0] y_out [0:COLS-1];

   systolic_array_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1)) dut (
      .clk(clk), .reset(reset), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
      .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .y_valid(y_valid),
      .y_out(y_out), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_vec(input string tag, input yvec_t got, input yvec_t exp);
      for (int c = 0; c < COLS; c++)
         check($sformatf("%s[%0d]", tag, c), 64'(got[c*AW +: AW]), 64'(exp[c*AW +: AW]));
   endtask

   function automatic avec_t mkv(input int a0, input int a1, input int a2, input int a3);
      int t [4];
      avec_t v;
      t = '{a0, a1, a2, a3};
      for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = t[i][DW-1:0];
      return v;
   endfunction

   function automatic yvec_t yv(input int y0, input int y1, input int y2, input int y3);
      int t [4];
      yvec_t v;
      t = '{y0, y1, y2, y3};
      for (int i = 0; i < COLS; i++) v[i*AW +: AW] = t[i][AW-1:0];
      return v;
   endfunction

   // Reference model: shadow/active weight matrices and expected results with due cycle.
   bit    run_mon = 0;
   int    sh_m  [ROWS][COLS];
   int    act_m [ROWS][COLS];
   bit    pend = 0, swap_now = 0;
   int    due_q [$];
   yvec_t y_q   [$];
   yvec_t last_y = '0;

   always @(negedge clk) begin : mon
      bit    exp_v, acc, sw_in;
      int    cnt, s;
      yvec_t ey;
      if (run_mon) begin
         exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
         check("y_valid", 64'(y_valid), 64'(exp_v));
         for (int c = 0; c < COLS; c++)
            check(exp_v ? "y_out" : "y_hold", 64'(y_out[c]),
                  64'(exp_v ? y_q[0][c*AW +: AW] : last_y[c*AW +: AW]));
         if (exp_v) last_y = y_q[0];
         cnt = due_q.size();
         check("a_ready", 64'(a_ready), 64'(!reset && !pend && !swap_now));
         check("busy", 64'(busy), 64'(cnt != 0 || pend || swap_now));
         if (reset) begin
            due_q.delete(); y_q.delete();
            pend = 0; swap_now = 0; last_y = '0;
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++) begin sh_m[r][c] = 0; act_m[r][c] = 0; end
         end else begin
            acc   = a_valid && !pend && !swap_now;
            sw_in = w_swap && !pend && !swap_now;
            if (exp_v) begin void'(due_q.pop_front()); void'(y_q.pop_front()); end
            if (acc) begin
               for (int c = 0; c < COLS; c++) begin
                  s = 0;
                  for (int r = 0; r < ROWS; r++) s += int'($signed(a_in[r])) * act_m[r][c];
                  ey[c*AW +: AW] = s[AW-1:0];
               end
               due_q.push_back(cyc + LAT);
               y_q.push_back(ey);
            end
            if (swap_now) act_m = sh_m;
            if (w_load) begin
               for (int r = ROWS - 1; r > 0; r--) sh_m[r] = sh_m[r-1];
               for (int c = 0; c < COLS; c++) sh_m[0][c] = int'($signed(w_in[c]));
            end
            if (swap_now) swap_now = 0;
            else if (pend) begin
               if (due_q.size() == 0) begin pend = 0; swap_now = 1; end
            end else if (sw_in) begin
               if (cnt == 0 && !acc) swap_now = 1;
               else pend = 1;
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic load_matrix(input wmat_t wm);
      for (int i = 0; i < ROWS; i++) begin
         w_load = 1'b1;
         for (int c = 0; c < COLS; c++) w_in[c] = wm[((ROWS-1-i)*COLS + c)*DW +: DW];
         sync();
      end
      w_load = 1'b0;
   endtask

   task automatic wait_ready();
      bit ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         ok = a_ready;
      end
      check("ready_timeout", 64'(ok), 64'd1);
      sync();
   endtask

   task automatic do_swap();
      w_swap = 1'b1;
      sync();
      w_swap = 1'b0;
      wait_ready();
   endtask

   task automatic send(input avec_t v, output int edge_no);
      bit ok = 0;
      a_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) a_in[r] = v[r*DW +: DW];
      edge_no = -1;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         ok = a_ready;
         sync();
         if (ok) edge_no = cyc;
      end
      a_valid = 1'b0;
      check("send_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_y(input int acc_edge, output yvec_t y, output int lat);
      bit seen = 0;
      y = '0;
      lat = -1;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (y_valid) begin
            seen = 1;
            lat = cyc - acc_edge;
            for (int c = 0; c < COLS; c++) y[c*AW +: AW] = y_out[c];
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wmat_t wm;
      yvec_t y, res [3];
      int    e, e1, e2, lat, lowc, nres;
      bit    hi;
      for (int i = 0; i < ROWS; i++) a_in[i] = '0;
      for (int i = 0; i < COLS; i++) w_in[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      run_mon = 1;
      reset   = 1'b0;

      @(negedge clk);
      check("rst_y_valid", 64'(y_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_a_ready", 64'(a_ready), 64'd1);
      for (int c = 0; c < COLS; c++) y[c*AW +: AW] = y_out[c];
      check_vec("rst_y_out", y, '0);
      sync();

      // Identity weights; y_valid shows in the cycle after edge accept+LAT-1.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[(r*COLS+c)*DW +: DW] = (r == c) ? 8'd1 : 8'd0;
      load_matrix(wm);
      do_swap();
      send(mkv(1, 2, 3, 4), e);
      wait_y(e, y, lat);
      check_vec("t1_y", y, yv(1, 2, 3, 4));
      check("t1_lat", 64'(lat), 64'(LAT - 1));
      sync();

      // W[r][c] = r+c, back-to-back with one bubble.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[(r*COLS+c)*DW +: DW] = 8'(r + c);
      load_matrix(wm);
      do_swap();
      send(mkv(1, 1, 1, 1), e1);
      sync();
      send(mkv(2, 0, 0, -1), e2);
      check("t2_gap", 64'(e2 - e1), 64'd2);
      wait_y(e1, y, lat);
      check_vec("t2_y0", y, yv(6, 10, 14, 18));
      wait_y(e2, y, lat);
      check_vec("t2_y1", y, yv(-3, -2, -1, 0));
      check("t2_lat", 64'(lat), 64'(LAT - 1));
      sync();

      // Signed extremes.
      for (int i = 0; i < ROWS*COLS; i++) wm[i*DW +: DW] = 8'h80;
      load_matrix(wm);
      do_swap();
      send(mkv(-128, -128, -128, -128), e);
      wait_y(e, y, lat);
      check_vec("t3_y", y, yv(65536, 65536, 65536, 65536));
      sync();

      // Swap with 3 vectors in flight: old weights (-128) for all of them.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[(r*COLS+c)*DW +: DW] = (r == c) ? 8'd1 : 8'd0;
      load_matrix(wm);
      send(mkv(1, 2, 3, 4), e);
      send(mkv(5, 6, 7, 8), e);
      send(mkv(-1, -2, -3, -4), e);
      w_swap = 1'b1;
      sync();
      w_swap = 1'b0;
      lowc = 0; nres = 0; hi = 0;
      for (int t = 0; t < 40 && !hi; t++) begin
         @(negedge clk);
         if (y_valid && nres < 3) begin
            for (int c = 0; c < COLS; c++) res[nres][c*AW +: AW] = y_out[c];
            nres++;
         end
         if (a_ready) hi = 1;
         else lowc++;
      end
      check("t4_ready_low", 64'(lowc), 64'd8);
      check("t4_nres", 64'(nres), 64'd3);
      check_vec("t4_old0", res[0], yv(-1280, -1280, -1280, -1280));
      check_vec("t4_old1", res[1], yv(-3328, -3328, -3328, -3328));
      check_vec("t4_old2", res[2], yv(1280, 1280, 1280, 1280));
      sync();
      send(mkv(1, 2, 3, 4), e);
      wait_y(e, y, lat);
      check_vec("t4_new", y, yv(1, 2, 3, 4));
      sync();

      // Load shadow while streaming, then w_load coinciding with the SWAP cycle.
      for (int i = 0; i < 6; i++) begin
         a_valid = 1'b1;
         w_load  = 1'b1;
         for (int r = 0; r < ROWS; r++) a_in[r] = DW'($urandom);
         for (int c = 0; c < COLS; c++) w_in[c] = DW'($urandom);
         sync();
      end
      a_valid = 1'b0;
      w_load  = 1'b0;
      hi = 0;
      for (int t = 0; t < 40 && !hi; t++) begin @(negedge clk); hi = !busy; end
      check("t5_idle", 64'(hi), 64'd1);
      sync();
      w_swap = 1'b1;
      sync();
      w_swap = 1'b0;
      w_load = 1'b1;
      for (int c = 0; c < COLS; c++) w_in[c] = DW'($urandom);
      sync();
      w_load = 1'b0;
      send(avec_t'({$urandom, $urandom}), e);
      send(avec_t'({$urandom, $urandom}), e);
      repeat (LAT + 2) sync();

      // Reset with 4 in flight.
      for (int i = 0; i < 4; i++) send(avec_t'($urandom), e);
      reset = 1'b1;
      sync();
      sync();
      reset = 1'b0;
      @(negedge clk);
      check("t6_busy", 64'(busy), 64'd0);
      lowc = 0;
      for (int t = 0; t < LAT + 4; t++) begin @(negedge clk); if (y_valid) lowc++; end
      check("t6_no_valid", 64'(lowc), 64'd0);
      sync();
      send(mkv(5, 6, 7, 8), e);
      wait_y(e, y, lat);
      check_vec("t6_zero", y, '0);
      check("t6_lat", 64'(lat), 64'(LAT - 1));
      sync();

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         a_valid = ($urandom_range(0, 9) < 7);
         w_load  = ($urandom_range(0, 9) < 2);
         w_swap  = ($urandom_range(0, 19) == 0);
         reset   = ($urandom_range(0, 199) == 0);
         for (int r = 0; r < ROWS; r++) a_in[r] = DW'($urandom);
         for (int c = 0; c < COLS; c++) w_in[c] = DW'($urandom);
         sync();
      end
      a_valid = 1'b0; w_load = 1'b0; w_swap = 1'b0; reset = 1'b0;
      repeat (3 * LAT) sync();
      check("drain_empty", 64'(due_q.size()), 64'd0);
      check("drain_busy", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
